// File: rtl/nibbleadd.sv
// nibbleadd: registered sum of one selected nibble pair
// from two byte operands; q[4] carries out.
module nibbleadd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       ctrl,
  output logic [4:0] q
);

  logic [3:0] a_n;
  logic [3:0] b_n;
  logic [4:0] sum;

  always_comb begin
    a_n = ctrl ? A[7:4] : A[3:0];
    b_n = ctrl ? B[7:4] : B[3:0];
    sum = {1'b0, a_n} + {1'b0, b_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 5'd0;
    else        q <= sum;
  end

endmodule

// File: tb/tb_nibbleadd.sv
// tb_nibbleadd: directed and random checks of nibbleadd
// against an arithmetic reference model.
module tb_nibbleadd;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       ctrl;
  logic [4:0] q;

  int pass_cnt;
  int total_cnt;

  nibbleadd dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .ctrl (ctrl),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [4:0] got,
                     input logic [4:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0d (%b) want %0d (%b)",
               tag, got, got, exp, exp);
    else
      pass_cnt++;
  endtask

  function automatic logic [4:0] model(input int a,
                                       input int b,
                                       input int c);
    int s;
    if (c != 0) s = (a / 16) + (b / 16);
    else        s = (a % 16) + (b % 16);
    return 5'(s);
  endfunction

  task automatic apply(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic       c,
                       input logic [4:0] exp,
                       input string      tag);
    @(negedge clk);
    A = a; B = b; ctrl = c;
    @(posedge clk);
    #1;
    chk(tag, q, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    A = 8'hAA; B = 8'h55; ctrl = 1'b0;

    // held in reset across several edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", q, 5'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_release", q, 5'd15);

    apply(8'hAA, 8'h55, 1'b1, 5'd15, "aa55_hi");
    apply(8'hCC, 8'h33, 1'b0, 5'd15, "cc33_lo");
    apply(8'hCC, 8'h33, 1'b1, 5'd15, "cc33_hi");
    apply(8'hFF, 8'hFF, 1'b0, 5'd30, "max_lo");
    apply(8'h80, 8'h80, 1'b1, 5'd16, "carry_hi");
    apply(8'h00, 8'h00, 1'b0, 5'd0,  "zero_lo");
    apply(8'h00, 8'h00, 1'b1, 5'd0,  "zero_hi");
    apply(8'h12, 8'h34, 1'b0, 5'd6,  "iso_lo");
    apply(8'h12, 8'h34, 1'b1, 5'd4,  "iso_hi");
    apply(8'hF2, 8'h34, 1'b0, 5'd6,  "iso_a_hi_chg");
    apply(8'h12, 8'h34, 1'b0, 5'd6,  "ctrl_only_a");
    apply(8'h12, 8'h34, 1'b1, 5'd4,  "ctrl_only_b");

    // X on unselected nibbles must not reach q
    apply({4'bxxxx, 4'h1}, {4'bxxxx, 4'h2}, 1'b0,
          5'd3, "x_unsel_lo");
    apply({4'h7, 4'bxxxx}, {4'h8, 4'bxxxx}, 1'b1,
          5'd15, "x_unsel_hi");

    // async reset mid-cycle while q is nonzero
    apply(8'h09, 8'h09, 1'b0, 5'd18, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", q, 5'd0);
    @(negedge clk);
    A = 8'h11; B = 8'h22; ctrl = 1'b0;
    @(posedge clk);
    #1;
    chk("async_hold", q, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 8'h45; B = 8'h67; ctrl = 1'b1;
    @(posedge clk);
    #1;
    chk("no_replay", q, 5'd10);

    // back-to-back random triples, one result per edge
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      apply(ra, rb, rc, model(int'(ra), int'(rb), int'(rc)),
            $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
